// File: rtl/neuron_timestep_sequencer.sv
// neuron_timestep_sequencer
//   Per-timestep controller for a single neuron. It loads the stored potential
//   and integrates signed synaptic weights from a stream of axon events. On
//   tick it applies the leak, then checks the thresholds, which may fire a
//   spike and reset the potential. It then writes the new potential back into
//   the neuron parameter store. The store only accepts external writes while
//   its Wishbone port is idle, so the write-back stalls until bus_busy_i is low.
//   A write-back that stalls too long is abandoned and flagged on timeout_o.
//
// Optional feature macro: NTS_SPIKE_COUNT_EN
//   When defined, adds CNT_W and spike_count_o. spike_count_o is a saturating
//   count of emitted spikes that only reset clears.
//
// Ports
//   wb_clk_i                in  1      clock (only clock)
//   wb_rst_i                in  1      synchronous active-high reset
//   start_i                 in  1      begin timestep (ignored while busy)
//   tick_i                  in  1      end-of-timestep strobe
//   evt_valid_i/evt_ready_o     1      axon event handshake
//   evt_type_i              in  2      weight select (weight_type1..4)
//   evt_conn_i              in  1      synapse connected (0: consume, no add)
//   voltage_potential_i     in  8      stored potential (signed)
//   pos/neg_threshold_i     in  8      firing / floor thresholds (signed)
//   leak_value_i            in  8      leak added on tick (signed)
//   weight_type1..4_i       in  8      synaptic weights (signed)
//   pos/neg_reset_i         in  8      post-threshold potentials (signed)
//   bus_busy_i              in  1      parameter store Wishbone cycle active
//   ext_voltage_potential_o out 8      write-back value (holds between writes)
//   ext_write_enable_o      out 1      write-back strobe, only in WB
//   spike_o                 out 1      one-cycle spike pulse
//   busy_o                  out 1      timestep in progress
//   done_o                  out 1      one-cycle end-of-timestep pulse
//   timeout_o               out 1      sticky write-back abort, cleared by start
//   spike_count_o           out CNT_W  (NTS_SPIKE_COUNT_EN only)
module neuron_timestep_sequencer #(
  parameter int WB_WAIT_MAX = 15
`ifdef NTS_SPIKE_COUNT_EN
  , parameter int CNT_W     = 16
`endif
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       start_i,
  input  logic       tick_i,
  input  logic       evt_valid_i,
  output logic       evt_ready_o,
  input  logic [1:0] evt_type_i,
  input  logic       evt_conn_i,
  input  logic [7:0] voltage_potential_i,
  input  logic [7:0] pos_threshold_i,
  input  logic [7:0] neg_threshold_i,
  input  logic [7:0] leak_value_i,
  input  logic [7:0] weight_type1_i,
  input  logic [7:0] weight_type2_i,
  input  logic [7:0] weight_type3_i,
  input  logic [7:0] weight_type4_i,
  input  logic [7:0] pos_reset_i,
  input  logic [7:0] neg_reset_i,
  input  logic       bus_busy_i,
  output logic [7:0] ext_voltage_potential_o,
  output logic       ext_write_enable_o,
  output logic       spike_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       timeout_o
`ifdef NTS_SPIKE_COUNT_EN
  , output logic [CNT_W-1:0] spike_count_o
`endif
);

  localparam int WC_W = (WB_WAIT_MAX < 1) ? 1 : $clog2(WB_WAIT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ACCUM, S_LEAK, S_FIRE, S_WB, S_DONE
  } state_t;

  state_t          r_state, w_state_next;
  logic [7:0]      r_v_acc, w_v_acc_next;
  logic [7:0]      r_ext_vp, w_ext_vp_next;
  logic [WC_W-1:0] r_wait_cnt, w_wait_cnt_next;
  logic            r_timeout, w_timeout_next;
  logic [7:0]      w_weight;
  logic [7:0]      w_fire_v;

  // Signed 8-bit add with clamping to [-128, 127].
  function automatic logic [7:0] sat8(input logic [7:0] a, input logic [7:0] b);
    logic signed [8:0] s;
    s = $signed({a[7], a}) + $signed({b[7], b});
    if (s > 9'sd127)
      return 8'h7F;
    else if (s < -9'sd128)
      return 8'h80;
    else
      return s[7:0];
  endfunction

  always_comb begin
    case (evt_type_i)
      2'd0:    w_weight = weight_type1_i;
      2'd1:    w_weight = weight_type2_i;
      2'd2:    w_weight = weight_type3_i;
      default: w_weight = weight_type4_i;
    endcase
  end

  // Threshold decision; the positive check takes priority over the negative one.
  always_comb begin
    if ($signed(r_v_acc) >= $signed(pos_threshold_i))
      w_fire_v = pos_reset_i;
    else if ($signed(r_v_acc) <= $signed(neg_threshold_i))
      w_fire_v = neg_reset_i;
    else
      w_fire_v = r_v_acc;
  end

  always_comb begin
    w_state_next       = r_state;
    w_v_acc_next       = r_v_acc;
    w_ext_vp_next      = r_ext_vp;
    w_wait_cnt_next    = r_wait_cnt;
    w_timeout_next     = r_timeout;
    evt_ready_o        = 1'b0;
    ext_write_enable_o = 1'b0;
    spike_o            = 1'b0;
    done_o             = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_timeout_next = 1'b0;
          w_state_next   = S_LOAD;
        end
      end
      S_LOAD: begin
        w_v_acc_next = voltage_potential_i;
        w_state_next = S_ACCUM;
      end
      S_ACCUM: begin
        evt_ready_o = 1'b1;
        // An event handshaken together with tick is still integrated.
        if (evt_valid_i && evt_conn_i)
          w_v_acc_next = sat8(r_v_acc, w_weight);
        if (tick_i)
          w_state_next = S_LEAK;
      end
      S_LEAK: begin
        w_v_acc_next = sat8(r_v_acc, leak_value_i);
        w_state_next = S_FIRE;
      end
      S_FIRE: begin
        spike_o         = ($signed(r_v_acc) >= $signed(pos_threshold_i));
        w_v_acc_next    = w_fire_v;
        // Present the write-back value for the whole WB phase and keep it after.
        w_ext_vp_next   = w_fire_v;
        w_wait_cnt_next = '0;
        w_state_next    = S_WB;
      end
      S_WB: begin
        ext_write_enable_o = 1'b1;
        if (!bus_busy_i) begin
          w_state_next = S_DONE;
        end else if (r_wait_cnt == WC_W'(WB_WAIT_MAX)) begin
          // Give up: the strobe is withdrawn in this cycle so no write lands.
          ext_write_enable_o = 1'b0;
          w_timeout_next     = 1'b1;
          w_state_next       = S_DONE;
        end else begin
          w_wait_cnt_next = r_wait_cnt + 1'b1;
        end
      end
      S_DONE: begin
        done_o       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state    <= S_IDLE;
      r_v_acc    <= 8'h00;
      r_ext_vp   <= 8'h00;
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_v_acc    <= w_v_acc_next;
      r_ext_vp   <= w_ext_vp_next;
      r_wait_cnt <= w_wait_cnt_next;
      r_timeout  <= w_timeout_next;
    end
  end

  assign ext_voltage_potential_o = r_ext_vp;
  assign busy_o                  = (r_state != S_IDLE);
  assign timeout_o               = r_timeout;

`ifdef NTS_SPIKE_COUNT_EN
  logic [CNT_W-1:0] r_spike_cnt;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)
      r_spike_cnt <= '0;
    else if (spike_o && (r_spike_cnt != {CNT_W{1'b1}}))
      r_spike_cnt <= r_spike_cnt + 1'b1;
  end

  assign spike_count_o = r_spike_cnt;
`endif

endmodule
